// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// Forwarding codes, FSM states, and the bubble control bundle.
package pipe_ctrl_pkg;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  localparam logic [13:0] NOP_CTRL = 14'b0;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Youngest producer wins; a load in EX is left to the load-use stall.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic [4:0] ex_rd,
    input logic       ex_en,
    input logic       ex_load,
    input logic [4:0] mem_rd,
    input logic       mem_en,
    input logic [4:0] wb_rd,
    input logic       wb_en
  );
    logic nz;
    nz = (src != 5'd0);
    fwd_sel = FWD_RF;
    priority case (1'b1)
      (nz && ex_en && !ex_load && ex_rd == src): fwd_sel = FWD_EX;
      (nz && mem_en && mem_rd == src):           fwd_sel = FWD_MEM;
      (nz && wb_en && wb_rd == src):             fwd_sel = FWD_WB;
      default:                                   fwd_sel = FWD_RF;
    endcase
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Signal bundle between the ID-side pipeline and the hazard controller.
// ctrl is the controller's view, pipe is the datapath's view.
interface pipeline_hazard_controller_if;
  import pipe_ctrl_pkg::*;

  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic        id_hilo_read;
  logic        id_muldiv_start;
  logic        id_muldiv_is_div;
  logic [4:0]  ex_rd;
  logic [4:0]  mem_rd;
  logic [4:0]  wb_rd;
  logic        ex_rf_enable;
  logic        mem_rf_enable;
  logic        wb_rf_enable;
  logic        ex_load_instr;
  logic        le_pc;
  logic        le_npc;
  logic        le_if_id;
  logic        ctrl_mux_sel;
  logic [1:0]  fwd_a_sel;
  logic [1:0]  fwd_b_sel;
  logic        muldiv_busy;
  logic        muldiv_done;
  logic [31:0] stall_cycles;

  modport ctrl (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt,
    input  id_hilo_read, id_muldiv_start,
    input  id_muldiv_is_div,
    input  ex_rd, mem_rd, wb_rd,
    input  ex_rf_enable, mem_rf_enable,
    input  wb_rf_enable, ex_load_instr,
    output le_pc, le_npc, le_if_id,
    output ctrl_mux_sel, fwd_a_sel, fwd_b_sel,
    output muldiv_busy, muldiv_done,
    output stall_cycles
  );

  modport pipe (
    output id_rs, id_rt, id_uses_rs, id_uses_rt,
    output id_hilo_read, id_muldiv_start,
    output id_muldiv_is_div,
    output ex_rd, mem_rd, wb_rd,
    output ex_rf_enable, mem_rf_enable,
    output wb_rf_enable, ex_load_instr,
    input  le_pc, le_npc, le_if_id,
    input  ctrl_mux_sel, fwd_a_sel, fwd_b_sel,
    input  muldiv_busy, muldiv_done,
    input  stall_cycles
  );

endinterface

// File: rtl/muldiv_busy_counter.sv
// Latency tracker for the HI/LO unit: loads on start, counts down,
// and pulses done on the cycle after the last busy cycle.
module muldiv_busy_counter #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy,
  output logic done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  always_comb begin
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (cnt_q != '0) begin
      cnt_d  = cnt_q - 1'b1;
      done_d = (cnt_q == CNT_W'(1));
    end
    if (start)
      cnt_d = is_div ? CNT_W'(DIV_CYCLES)
                     : CNT_W'(MULT_CYCLES);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign busy = (cnt_q != '0);
  assign done = done_q;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Five-stage pipeline sequencer: boot bubbles, load-use and HI/LO
// stalls, operand forwarding selects and a stall-cycle counter.
module pipeline_hazard_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES = 2,
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_hilo_read,
  input  logic        id_muldiv_start,
  input  logic        id_muldiv_is_div,
  input  logic [4:0]  ex_rd,
  input  logic [4:0]  mem_rd,
  input  logic [4:0]  wb_rd,
  input  logic        ex_rf_enable,
  input  logic        mem_rf_enable,
  input  logic        wb_rf_enable,
  input  logic        ex_load_instr,
  output logic        le_pc,
  output logic        le_npc,
  output logic        le_if_id,
  output logic        ctrl_mux_sel,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel,
  output logic        muldiv_busy,
  output logic        muldiv_done,
  output logic [31:0] stall_cycles
);

  localparam int BOOT_W = $clog2(BOOT_CYCLES + 2);

  state_e            state_q, state_d;
  logic [BOOT_W-1:0] boot_cnt_q, boot_cnt_d;
  logic [31:0]       stall_cnt_q, stall_cnt_d;

  logic run;
  logic lu_haz;
  logic md_haz;
  logic stall;
  logic md_start;

  muldiv_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start),
    .is_div (id_muldiv_is_div),
    .busy   (muldiv_busy),
    .done   (muldiv_done)
  );

  always_comb begin
    run    = (state_q == RUN);
    lu_haz = ex_load_instr && ex_rf_enable
          && (ex_rd != 5'd0)
          && ((id_uses_rs && id_rs == ex_rd)
           || (id_uses_rt && id_rt == ex_rd));
    md_haz = muldiv_busy
          && (id_hilo_read || id_muldiv_start);
    stall  = lu_haz || md_haz;

    le_pc        = run && !stall;
    le_npc       = le_pc;
    le_if_id     = le_pc;
    ctrl_mux_sel = le_pc;
    md_start     = run && !stall && id_muldiv_start;

    fwd_a_sel = fwd_sel(id_rs, ex_rd, ex_rf_enable,
                        ex_load_instr, mem_rd,
                        mem_rf_enable, wb_rd,
                        wb_rf_enable);
    fwd_b_sel = fwd_sel(id_rt, ex_rd, ex_rf_enable,
                        ex_load_instr, mem_rd,
                        mem_rf_enable, wb_rd,
                        wb_rf_enable);
  end

  always_comb begin
    state_d     = state_q;
    boot_cnt_d  = boot_cnt_q;
    stall_cnt_d = stall_cnt_q;
    unique case (state_q)
      BOOT: begin
        if (boot_cnt_q == BOOT_W'(BOOT_CYCLES))
          state_d = RUN;
        else
          boot_cnt_d = boot_cnt_q + 1'b1;
      end
      RUN: begin
        if (stall && stall_cnt_q != '1)
          stall_cnt_d = stall_cnt_q + 1'b1;
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= BOOT;
      boot_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      boot_cnt_q  <= boot_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: boot, load-use,
// forwarding priority, mult/div stalls and reset during a divide.
module tb_pipeline_hazard_controller;
  import pipe_ctrl_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   exp_stall;

  pipeline_hazard_controller_if hif ();

  pipeline_hazard_controller dut (
    .clk              (clk),
    .reset            (reset),
    .id_rs            (hif.id_rs),
    .id_rt            (hif.id_rt),
    .id_uses_rs       (hif.id_uses_rs),
    .id_uses_rt       (hif.id_uses_rt),
    .id_hilo_read     (hif.id_hilo_read),
    .id_muldiv_start  (hif.id_muldiv_start),
    .id_muldiv_is_div (hif.id_muldiv_is_div),
    .ex_rd            (hif.ex_rd),
    .mem_rd           (hif.mem_rd),
    .wb_rd            (hif.wb_rd),
    .ex_rf_enable     (hif.ex_rf_enable),
    .mem_rf_enable    (hif.mem_rf_enable),
    .wb_rf_enable     (hif.wb_rf_enable),
    .ex_load_instr    (hif.ex_load_instr),
    .le_pc            (hif.le_pc),
    .le_npc           (hif.le_npc),
    .le_if_id         (hif.le_if_id),
    .ctrl_mux_sel     (hif.ctrl_mux_sel),
    .fwd_a_sel        (hif.fwd_a_sel),
    .fwd_b_sel        (hif.fwd_b_sel),
    .muldiv_busy      (hif.muldiv_busy),
    .muldiv_done      (hif.muldiv_done),
    .stall_cycles     (hif.stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_in();
    hif.id_rs            = 5'd0;
    hif.id_rt            = 5'd0;
    hif.id_uses_rs       = 1'b0;
    hif.id_uses_rt       = 1'b0;
    hif.id_hilo_read     = 1'b0;
    hif.id_muldiv_start  = 1'b0;
    hif.id_muldiv_is_div = 1'b0;
    hif.ex_rd            = 5'd0;
    hif.mem_rd           = 5'd0;
    hif.wb_rd            = 5'd0;
    hif.ex_rf_enable     = 1'b0;
    hif.mem_rf_enable    = 1'b0;
    hif.wb_rf_enable     = 1'b0;
    hif.ex_load_instr    = 1'b0;
  endtask

  task automatic check_boot(input string tag);
    step();
    check({tag, "_b1_ctrl"}, 32'(hif.ctrl_mux_sel), 0);
    check({tag, "_b1_lepc"}, 32'(hif.le_pc), 0);
    step();
    check({tag, "_b2_ctrl"}, 32'(hif.ctrl_mux_sel), 0);
    check({tag, "_b2_lepc"}, 32'(hif.le_pc), 0);
    step();
    check({tag, "_run_ctrl"}, 32'(hif.ctrl_mux_sel), 1);
    check({tag, "_run_lepc"}, 32'(hif.le_pc), 1);
    check({tag, "_run_lenpc"}, 32'(hif.le_npc), 1);
    check({tag, "_run_leifid"}, 32'(hif.le_if_id), 1);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    exp_stall = 0;
    clear_in();
    reset = 1'b1;
    repeat (2) @(negedge clk);

    check("rst_lepc", 32'(hif.le_pc), 0);
    check("rst_ctrl", 32'(hif.ctrl_mux_sel), 0);
    check("rst_fwda", 32'(hif.fwd_a_sel), 0);
    check("rst_fwdb", 32'(hif.fwd_b_sel), 0);
    check("rst_busy", 32'(hif.muldiv_busy), 0);
    check("rst_done", 32'(hif.muldiv_done), 0);
    check("rst_stall", hif.stall_cycles, 0);

    reset = 1'b0;
    check_boot("boot");
    check("boot_stall", hif.stall_cycles, 0);

    // load-use: load r5 in EX, ID reads r5
    hif.ex_load_instr = 1'b1;
    hif.ex_rf_enable  = 1'b1;
    hif.ex_rd         = 5'd5;
    hif.id_rs         = 5'd5;
    hif.id_uses_rs    = 1'b1;
    #1;
    check("lu_lepc", 32'(hif.le_pc), 0);
    check("lu_ctrl", 32'(hif.ctrl_mux_sel), 0);
    check("lu_fwda_noload", 32'(hif.fwd_a_sel), 32'(FWD_RF));
    exp_stall++;
    step();
    hif.ex_load_instr = 1'b0;
    hif.ex_rf_enable  = 1'b0;
    hif.ex_rd         = 5'd0;
    hif.mem_rd        = 5'd5;
    hif.mem_rf_enable = 1'b1;
    #1;
    check("lu_after_lepc", 32'(hif.le_pc), 1);
    check("lu_after_ctrl", 32'(hif.ctrl_mux_sel), 1);
    check("lu_after_fwda", 32'(hif.fwd_a_sel), 32'(FWD_MEM));
    check("lu_stall", hif.stall_cycles, 32'(exp_stall));
    step();
    clear_in();

    // forwarding priority
    hif.ex_rd = 5'd7; hif.mem_rd = 5'd7; hif.wb_rd = 5'd7;
    hif.ex_rf_enable  = 1'b1;
    hif.mem_rf_enable = 1'b1;
    hif.wb_rf_enable  = 1'b1;
    hif.id_rs = 5'd7; hif.id_uses_rs = 1'b1;
    hif.id_rt = 5'd7; hif.id_uses_rt = 1'b1;
    #1;
    check("fwd_ex_a", 32'(hif.fwd_a_sel), 1);
    check("fwd_ex_b", 32'(hif.fwd_b_sel), 1);
    check("fwd_ex_lepc", 32'(hif.le_pc), 1);
    hif.ex_rf_enable = 1'b0;
    #1;
    check("fwd_mem_a", 32'(hif.fwd_a_sel), 2);
    hif.mem_rf_enable = 1'b0;
    #1;
    check("fwd_wb_a", 32'(hif.fwd_a_sel), 3);
    hif.id_rt = 5'd9;
    #1;
    check("fwd_rf_b", 32'(hif.fwd_b_sel), 0);
    hif.ex_rf_enable  = 1'b1;
    hif.mem_rf_enable = 1'b1;
    hif.ex_rd = 5'd0; hif.mem_rd = 5'd0; hif.wb_rd = 5'd0;
    hif.id_rs = 5'd0; hif.id_rt = 5'd0;
    #1;
    check("fwd_r0_a", 32'(hif.fwd_a_sel), 0);
    check("fwd_r0_b", 32'(hif.fwd_b_sel), 0);
    step();
    clear_in();

    // mult followed by mfhi
    hif.id_muldiv_start = 1'b1;
    #1;
    check("mul_accept", 32'(hif.le_pc), 1);
    step();
    hif.id_muldiv_start = 1'b0;
    hif.id_hilo_read    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("mul_busy", 32'(hif.muldiv_busy), 1);
      check("mul_stall_lepc", 32'(hif.le_pc), 0);
      check("mul_stall_done", 32'(hif.muldiv_done), 0);
      exp_stall++;
      step();
    end
    check("mul_done", 32'(hif.muldiv_done), 1);
    check("mul_idle", 32'(hif.muldiv_busy), 0);
    check("mfhi_go", 32'(hif.le_pc), 1);
    check("mul_stallcnt", hif.stall_cycles, 32'(exp_stall));
    step();
    hif.id_hilo_read = 1'b0;
    check("mul_done_once", 32'(hif.muldiv_done), 0);
    check("mul_stall_hold", hif.stall_cycles, 32'(exp_stall));

    // back-to-back divides
    hif.id_muldiv_start  = 1'b1;
    hif.id_muldiv_is_div = 1'b1;
    #1;
    check("div1_accept", 32'(hif.le_pc), 1);
    step();
    for (int i = 0; i < 32; i++) begin
      check("div_busy", 32'(hif.muldiv_busy), 1);
      check("div_stall_lepc", 32'(hif.le_pc), 0);
      exp_stall++;
      step();
    end
    check("div_done", 32'(hif.muldiv_done), 1);
    check("div2_accept", 32'(hif.le_pc), 1);
    check("div_stallcnt", hif.stall_cycles, 32'(exp_stall));
    step();
    hif.id_muldiv_start  = 1'b0;
    hif.id_muldiv_is_div = 1'b0;
    check("div2_busy", 32'(hif.muldiv_busy), 1);
    check("div2_nodone", 32'(hif.muldiv_done), 0);

    // run down to counter = 10, then reset
    repeat (22) step();
    check("div2_still_busy", 32'(hif.muldiv_busy), 1);
    reset = 1'b1;
    #1;
    check("rstdiv_busy", 32'(hif.muldiv_busy), 0);
    check("rstdiv_done", 32'(hif.muldiv_done), 0);
    check("rstdiv_lepc", 32'(hif.le_pc), 0);
    check("rstdiv_stall", hif.stall_cycles, 0);
    step();
    reset = 1'b0;
    check_boot("reboot");
    for (int i = 0; i < 12; i++) begin
      check("rstdiv_nodone", 32'(hif.muldiv_done), 0);
      check("rstdiv_idle", 32'(hif.muldiv_busy), 0);
      step();
    end
    check("reboot_stall", hif.stall_cycles, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
